// File: rtl/pixel_uart_streamer.sv
// pixel_uart_streamer: buffers pixel words in a small FIFO and hands them to a
// UART TX stage one byte at a time, pacing each byte on the stage's busy flag.
module pixel_uart_streamer #(
   parameter int PIXEL_BITS = 24,
   parameter int FIFO_DEPTH = 16,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   input  logic [PIXEL_BITS-1:0]         pix_data,
   output logic                          tx_en,
   output logic [7:0]                    tx_data,
   input  logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          streamer_busy
);

   localparam int BYTES = PIXEL_BITS / 8;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
   // byte_idx never exceeds 3 because a pixel is at most 32 bits wide
   localparam logic [1:0]       LAST_IDX   = 2'(BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      ACK,
      DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [PIXEL_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]      level_q;
   logic [PIXEL_BITS-1:0] shift_q;
   logic [PIXEL_BITS-1:0] shift_adv;
   logic [PIXEL_BITS-1:0] head_word;
   logic [1:0]            byte_idx_q;
   logic                  tx_en_q;
   logic [7:0]            tx_data_q;
   logic                  push;
   logic                  pop;
   logic                  advance;

   // Byte that leaves first from a word, depending on the configured order.
   function automatic logic [7:0] lead_byte(input logic [PIXEL_BITS-1:0] w);
      if (MSB_FIRST) return w[PIXEL_BITS-1 -: 8];
      else           return w[7:0];
   endfunction

   assign pix_ready     = (level_q != FULL_LEVEL);
   assign push          = pix_valid && pix_ready;
   assign head_word     = mem[rd_ptr_q];
   assign shift_adv     = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
   assign fifo_level    = level_q;
   assign tx_en         = tx_en_q;
   assign tx_data       = tx_data_q;
   assign streamer_busy = (state_q != IDLE) || (level_q != '0);

   // Pixel storage: written on every accepted push.
   // NOTE: the storage array has no reset; the level counter alone says which
   // entries are meaningful, so clearing the array would only cost flops.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= pix_data;
   end

   // FIFO pointers and occupancy; the level alone decides full and empty.
   // NOTE: every sequential assignment is non-blocking so all registers update
   // together from the values that were current before the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic and the pop/advance strobes that drive the datapath.
   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = ACK;
         ACK: begin
            if (tx_busy) state_d = DRAIN;
         end
         DRAIN: begin
            if (!tx_busy) begin
               if (byte_idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  advance = 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte datapath: tx_data is loaded on the edge that enters ISSUE so it is
   // already stable when the TX stage samples it alongside tx_en.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shift_q    <= '0;
         byte_idx_q <= '0;
         tx_data_q  <= '0;
         tx_en_q    <= 1'b0;
      end else begin
         if (pop) begin
            shift_q    <= head_word;
            byte_idx_q <= '0;
            tx_data_q  <= lead_byte(head_word);
         end else if (advance) begin
            shift_q    <= shift_adv;
            byte_idx_q <= byte_idx_q + 2'd1;
            tx_data_q  <= lead_byte(shift_adv);
         end
         // ISSUE always exits after one cycle, so this pulse is one cycle wide.
         tx_en_q <= (state_d == ISSUE);
      end
   end

endmodule
